// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one slow memory port between the I-cache and D-cache.
// D-cache has priority; a streak counter limits how many consecutive D grants
// may be issued while the I-cache waits. One transaction outstanding at a time;
// the outgoing request is registered. After each completion a one-cycle TURN
// state gives the finished requester time to drop its request.
// Optional build macro: MEM_ARB_STATS_EN adds saturating grant/wait counters.
module mem_arbiter #(
  parameter int AW           = 28,
  parameter int DW           = 128,
  parameter int D_STREAK_MAX = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  // I-cache side
  input  logic          mem_read_I,
  input  logic          mem_write_I,
  input  logic [AW-1:0] mem_addr_I,
  input  logic [DW-1:0] mem_wdata_I,
  output logic [DW-1:0] mem_rdata_I,
  output logic          mem_ready_I,
  // D-cache side
  input  logic          mem_read_D,
  input  logic          mem_write_D,
  input  logic [AW-1:0] mem_addr_D,
  input  logic [DW-1:0] mem_wdata_D,
  output logic [DW-1:0] mem_rdata_D,
  output logic          mem_ready_D,
  // memory side
  output logic          mem_read,
  output logic          mem_write,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [15:0]   stat_grant_I,
  output logic [15:0]   stat_grant_D,
  output logic [15:0]   stat_wait_I
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    TURN   = 2'd3
  } state_t;

  localparam logic [3:0] STREAK_MAX = 4'(D_STREAK_MAX);

  state_t     state_reg;
  state_t     state_next;
  logic [3:0] streak_reg;
  logic [3:0] streak_next;

  logic pend_i;
  logic pend_d;
  logic streak_at_max;
  logic grant_i;
  logic grant_d;
  logic busy_done;

  // A requester is pending whenever either of its strobes is high.
  assign pend_i        = mem_read_I | mem_write_I;
  assign pend_d        = mem_read_D | mem_write_D;
  assign streak_at_max = (streak_reg == STREAK_MAX);

  // The owned transaction finishes when memory reports ready while busy.
  assign busy_done = ((state_reg == BUSY_I) || (state_reg == BUSY_D)) && mem_ready;

  // Arbitration: only in IDLE; D wins unless I has waited out a full streak.
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (state_reg == IDLE) begin
      if (pend_d && !(pend_i && streak_at_max)) begin
        grant_d = 1'b1;
      end else if (pend_i) begin
        grant_i = 1'b1;
      end
    end
  end

  // Next-state logic for the ownership FSM.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (grant_d) begin
          state_next = BUSY_D;
        end else if (grant_i) begin
          state_next = BUSY_I;
        end
      end
      BUSY_I, BUSY_D: begin
        if (mem_ready) begin
          state_next = TURN;
        end
      end
      TURN: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Streak: counts D grants made over a waiting I; any other grant restarts it.
  always_comb begin
    streak_next = streak_reg;
    if (grant_i) begin
      streak_next = 4'd0;
    end else if (grant_d) begin
      if (pend_i) begin
        streak_next = streak_at_max ? streak_reg : (streak_reg + 4'd1);
      end else begin
        streak_next = 4'd0;
      end
    end
  end

  // Streak counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      streak_reg <= 4'd0;
    end else begin
      streak_reg <= streak_next;
    end
  end

  // Registered memory request: loaded on a grant, strobes cleared on completion.
  // A requester raising read and write together gets only its write forwarded;
  // its read is picked up by a later arbitration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (grant_d) begin
      mem_read  <= mem_read_D & ~mem_write_D;
      mem_write <= mem_write_D;
      mem_addr  <= mem_addr_D;
      mem_wdata <= mem_wdata_D;
    end else if (grant_i) begin
      mem_read  <= mem_read_I & ~mem_write_I;
      mem_write <= mem_write_I;
      mem_addr  <= mem_addr_I;
      mem_wdata <= mem_wdata_I;
    end else if (busy_done) begin
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
    end
  end

  // Ready and read data go straight through to the current owner only;
  // a ready seen in IDLE or TURN is dropped.
  always_comb begin
    mem_ready_I = (state_reg == BUSY_I) && mem_ready;
    mem_ready_D = (state_reg == BUSY_D) && mem_ready;
    mem_rdata_I = mem_ready_I ? mem_rdata : '0;
    mem_rdata_D = mem_ready_D ? mem_rdata : '0;
  end

`ifdef MEM_ARB_STATS_EN
  // Statistics: [0] I grants, [1] D grants, [2] cycles I waits without owning.
  logic [2:0]  stat_inc;
  logic [15:0] stat_val [3];

  assign stat_inc[0] = grant_i;
  assign stat_inc[1] = grant_d;
  assign stat_inc[2] = pend_i && (state_reg != BUSY_I);

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_stat
      logic [15:0] cnt_reg;

      // Saturating event counter.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_reg <= 16'd0;
        end else if (stat_inc[gi] && (cnt_reg != 16'hFFFF)) begin
          cnt_reg <= cnt_reg + 16'd1;
        end
      end

      assign stat_val[gi] = cnt_reg;
    end
  endgenerate

  assign stat_grant_I = stat_val[0];
  assign stat_grant_D = stat_val[1];
  assign stat_wait_I  = stat_val[2];
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter: linear sequence of steps with
// hand-computed expectations checked by immediate assertions.
module tb_mem_arbiter;

  localparam int AW = 28;
  localparam int DW = 128;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          mem_read_I, mem_write_I;
  logic [AW-1:0] mem_addr_I;
  logic [DW-1:0] mem_wdata_I;
  logic [DW-1:0] mem_rdata_I;
  logic          mem_ready_I;
  logic          mem_read_D, mem_write_D;
  logic [AW-1:0] mem_addr_D;
  logic [DW-1:0] mem_wdata_D;
  logic [DW-1:0] mem_rdata_D;
  logic          mem_ready_D;
  logic          mem_read, mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;
`ifdef MEM_ARB_STATS_EN
  logic [15:0]   stat_grant_I, stat_grant_D, stat_wait_I;
`endif

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.AW(AW), .DW(DW), .D_STREAK_MAX(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mem_read_I  (mem_read_I),
    .mem_write_I (mem_write_I),
    .mem_addr_I  (mem_addr_I),
    .mem_wdata_I (mem_wdata_I),
    .mem_rdata_I (mem_rdata_I),
    .mem_ready_I (mem_ready_I),
    .mem_read_D  (mem_read_D),
    .mem_write_D (mem_write_D),
    .mem_addr_D  (mem_addr_D),
    .mem_wdata_D (mem_wdata_D),
    .mem_rdata_D (mem_rdata_D),
    .mem_ready_D (mem_ready_D),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_ready   (mem_ready)
`ifdef MEM_ARB_STATS_EN
    ,
    .stat_grant_I(stat_grant_I),
    .stat_grant_D(stat_grant_D),
    .stat_wait_I (stat_wait_I)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Memory completes the owned transaction; the owner sees ready and, in TURN,
  // drops the requests selected by drop_i/drop_d. Returns at a negedge in IDLE.
  task automatic finish_txn(input string tag, input bit exp_d, input logic [127:0] data,
                            input bit drop_i, input bit drop_d);
    mem_ready = 1'b1;
    mem_rdata = data;
    #1;
    chk({tag, " ready_D"}, 128'(mem_ready_D), 128'(exp_d));
    chk({tag, " ready_I"}, 128'(mem_ready_I), 128'(!exp_d));
    chk({tag, " rdata"}, exp_d ? mem_rdata_D : mem_rdata_I, data);
    chk({tag, " rdata_other"}, exp_d ? mem_rdata_I : mem_rdata_D, 128'd0);
    tick();
    mem_ready = 1'b0;
    mem_rdata = '0;
    if (drop_i) begin mem_read_I = 1'b0; mem_write_I = 1'b0; end
    if (drop_d) begin mem_read_D = 1'b0; mem_write_D = 1'b0; end
    #1;
    chk({tag, " turn_read"}, 128'(mem_read), 128'd0);
    chk({tag, " turn_write"}, 128'(mem_write), 128'd0);
    chk({tag, " turn_ready_I"}, 128'(mem_ready_I), 128'd0);
    tick();
  endtask

`ifdef MEM_ARB_STATS_EN
  // One read from a single requester, completed with the given data.
  task automatic single_read(input bit is_d, input logic [AW-1:0] addr);
    if (is_d) begin mem_read_D = 1'b1; mem_addr_D = addr; end
    else begin mem_read_I = 1'b1; mem_addr_I = addr; end
    tick();
    chk("st grant addr", 128'(mem_addr), 128'(addr));
    finish_txn("st", is_d, 128'h55, !is_d, is_d);
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    mem_read_I = 0; mem_write_I = 0; mem_addr_I = '0; mem_wdata_I = '0;
    mem_read_D = 0; mem_write_D = 0; mem_addr_D = '0; mem_wdata_D = '0;
    mem_rdata = '0; mem_ready = 0;

    // Reset state
    tick();
    chk("rst mem_read", 128'(mem_read), 128'd0);
    chk("rst mem_write", 128'(mem_write), 128'd0);
    chk("rst mem_addr", 128'(mem_addr), 128'd0);
    chk("rst mem_wdata", mem_wdata, 128'd0);
    chk("rst ready_I", 128'(mem_ready_I), 128'd0);
    chk("rst ready_D", 128'(mem_ready_D), 128'd0);
    rst_n = 1'b1;
    tick();

    // Spurious mem_ready in IDLE with no requests
    mem_ready = 1'b1;
    mem_rdata = 128'hFF;
    #1;
    chk("spur ready_I", 128'(mem_ready_I), 128'd0);
    chk("spur ready_D", 128'(mem_ready_D), 128'd0);
    chk("spur rdata_I", mem_rdata_I, 128'd0);
    chk("spur rdata_D", mem_rdata_D, 128'd0);
    tick();
    mem_ready = 1'b0;
    mem_rdata = '0;
    chk("spur mem_read", 128'(mem_read), 128'd0);
    chk("spur mem_write", 128'(mem_write), 128'd0);
    chk("spur mem_addr", 128'(mem_addr), 128'd0);
    $display("txn spurious ready in IDLE done");

    // Single I read, memory ready after 5 cycles
    mem_read_I = 1'b1;
    mem_addr_I = 28'h0000010;
    #1;
    chk("t1 no strobe yet", 128'(mem_read), 128'd0);
    tick();
    chk("t1 mem_read", 128'(mem_read), 128'd1);
    chk("t1 mem_write", 128'(mem_write), 128'd0);
    chk("t1 mem_addr", 128'(mem_addr), 128'h10);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t1 wait ready_I", 128'(mem_ready_I), 128'd0);
      chk("t1 wait ready_D", 128'(mem_ready_D), 128'd0);
      chk("t1 wait strobe", 128'(mem_read), 128'd1);
    end
    finish_txn("t1", 1'b0, 128'hA5, 1'b1, 1'b0);
    $display("txn single I read addr=0000010 done");

    // I and D read in the same cycle: D first, then I
    mem_read_I = 1'b1; mem_addr_I = 28'h0000100;
    mem_read_D = 1'b1; mem_addr_D = 28'h0000200;
    tick();
    chk("t2 D first addr", 128'(mem_addr), 128'h200);
    chk("t2 D first read", 128'(mem_read), 128'd1);
    finish_txn("t2d", 1'b1, 128'hBEEF, 1'b0, 1'b1);
    chk("t2 idle no strobe", 128'(mem_read), 128'd0);
    tick();
    chk("t2 I second addr", 128'(mem_addr), 128'h100);
    chk("t2 I second read", 128'(mem_read), 128'd1);
    finish_txn("t2i", 1'b0, 128'hCAFE, 1'b1, 1'b0);
    $display("txn I/D collision done");

    // Starvation guard: D,D,D,D then I, then D again (streak restarted)
    mem_read_I = 1'b1; mem_addr_I = 28'h0000300;
    mem_read_D = 1'b1; mem_addr_D = 28'h0000400;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("t3 grant addr", 128'(mem_addr), (k == 4) ? 128'h300 : 128'h400);
      chk("t3 grant read", 128'(mem_read), 128'd1);
      finish_txn("t3", (k != 4), 128'(k + 1), (k == 5), (k == 5));
      $display("txn streak grant %0d to %s", k + 1, (k == 4) ? "I" : "D");
    end

    // D read+write together: only the write is forwarded
    mem_read_D = 1'b1; mem_write_D = 1'b1;
    mem_addr_D = 28'h0000020; mem_wdata_D = 128'h1234;
    tick();
    chk("t4 mem_write", 128'(mem_write), 128'd1);
    chk("t4 mem_read", 128'(mem_read), 128'd0);
    chk("t4 mem_wdata", mem_wdata, 128'h1234);
    chk("t4 mem_addr", 128'(mem_addr), 128'h20);
    finish_txn("t4w", 1'b1, 128'd0, 1'b0, 1'b0);
    // The cache retires its write and keeps the read pending.
    mem_write_D = 1'b0;
    tick();
    chk("t4 read later", 128'(mem_read), 128'd1);
    chk("t4 read later write", 128'(mem_write), 128'd0);
    finish_txn("t4r", 1'b1, 128'h77, 1'b0, 1'b1);
    $display("txn D read+write addr=0000020 done");

    // Reset during BUSY_D
    mem_read_D = 1'b1; mem_addr_D = 28'h0000050;
    tick();
    chk("t5 granted", 128'(mem_read), 128'd1);
    rst_n = 1'b0;
    mem_ready = 1'b1;
    #1;
    chk("t5 rst mem_read", 128'(mem_read), 128'd0);
    chk("t5 rst mem_write", 128'(mem_write), 128'd0);
    chk("t5 rst mem_addr", 128'(mem_addr), 128'd0);
    chk("t5 rst ready_D", 128'(mem_ready_D), 128'd0);
    tick();
    chk("t5 in rst ready_D", 128'(mem_ready_D), 128'd0);
    rst_n = 1'b1;
    mem_ready = 1'b0;
    #1;
    chk("t5 release no strobe", 128'(mem_read), 128'd0);
    tick();
    chk("t5 regrant read", 128'(mem_read), 128'd1);
    chk("t5 regrant addr", 128'(mem_addr), 128'h50);
    finish_txn("t5", 1'b1, 128'h99, 1'b0, 1'b1);
    $display("txn reset during BUSY_D done");

`ifdef MEM_ARB_STATS_EN
    // Statistics: fresh reset, then 3 I and 2 D grants
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("st clr grant_I", 128'(stat_grant_I), 128'd0);
    chk("st clr grant_D", 128'(stat_grant_D), 128'd0);
    tick();
    single_read(1'b0, 28'h1);
    single_read(1'b0, 28'h2);
    single_read(1'b0, 28'h3);
    single_read(1'b1, 28'h4);
    single_read(1'b1, 28'h5);
    chk("st grant_I", 128'(stat_grant_I), 128'd3);
    chk("st grant_D", 128'(stat_grant_D), 128'd2);
    chk("st wait_I", 128'(stat_wait_I), 128'd3);
    $display("txn stats 3 I + 2 D done");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
